// File: rtl/kgp_cycle_sequencer.sv
// kgp_cycle_sequencer: multi-cycle fetch/decode/exec/mem/wb sequencer with memory timeout; optional SEQ_RETIRE_CNT_EN adds retireCount
module kgp_cycle_sequencer #(
    parameter logic [5:0] HALT_OP = 6'b111111,
    parameter int         TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [5:0] opcode,
    input  logic       memRead,
    input  logic       memWrite,
    input  logic       regwrite,
    input  logic       branch,
    input  logic       branchTaken,
    input  logic       memAck,
    output logic       memReq,
    output logic       memWe,
    output logic       memIsFetch,
    output logic       irLoad,
    output logic       pcWrite,
    output logic       pcSrcBranch,
    output logic       aluLatch,
    output logic       regWriteEn,
    output logic [2:0] state,
    output logic       halted,
    output logic       memErr
`ifdef SEQ_RETIRE_CNT_EN
    ,
    output logic [31:0] retireCount
`endif
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERR} state_t;
    localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIM = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
    state_t state_q, state_d, nxt;
    logic [CW-1:0] cnt_q, cnt_d;
    logic timed_out, take_br;
    assign nxt = run ? FETCH : IDLE;
    assign timed_out = (TIMEOUT != 0) && (cnt_q == LIM);
    assign take_br = (state_q == EXEC) && branch && branchTaken;
    assign cnt_d = (state_d != state_q) ? '0 : (TIMEOUT != 0 && memReq && !memAck) ? cnt_q + 1'b1 : cnt_q;
    assign state = state_q;
    // state and wait counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
    // next state; an ack in the timeout cycle takes the normal path
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = nxt;
            FETCH:   state_d = memAck ? DECODE : timed_out ? ERR : FETCH;
            DECODE:  state_d = (opcode == HALT_OP) ? HALT : EXEC;
            EXEC:    state_d = (memRead | memWrite) ? MEM : regwrite ? WB : nxt;
            MEM:     state_d = memAck ? (memRead ? WB : nxt) : timed_out ? ERR : MEM;
            WB:      state_d = nxt;
            default: state_d = state_q;
        endcase
    end
    // Moore memory/status decodes and single-cycle Mealy strobes
    always_comb begin
        memReq      = (state_q == FETCH) || (state_q == MEM);
        memWe       = (state_q == MEM) && memWrite;
        memIsFetch  = (state_q == FETCH);
        irLoad      = (state_q == FETCH) && memAck;
        pcWrite     = ((state_q == FETCH) && memAck) || take_br;
        pcSrcBranch = take_br;
        aluLatch    = (state_q == EXEC);
        regWriteEn  = (state_q == WB);
        halted      = (state_q == HALT);
        memErr      = (state_q == ERR);
    end
`ifdef SEQ_RETIRE_CNT_EN
    logic [31:0] retire_q;
    logic retire;
    assign retire = ((state_q == EXEC) && !(memRead | memWrite | regwrite)) ||
                    ((state_q == MEM) && memAck && !memRead) || (state_q == WB);
    assign retireCount = retire_q;
    // count instructions completing through a Next decision
    always_ff @(posedge clk) begin
        if (!rst_n) retire_q <= '0;
        else if (retire) retire_q <= retire_q + 32'd1;
    end
`endif
endmodule

// File: tb/tb_kgp_cycle_sequencer.sv
// tb_kgp_cycle_sequencer: directed vector table plus timeout sequences
module tb_kgp_cycle_sequencer;
    logic clk = 1'b0;
    logic rst_n, run, memRead, memWrite, regwrite, branch, branchTaken, memAck;
    logic [5:0] opcode;
    logic memReq, memWe, memIsFetch, irLoad, pcWrite, pcSrcBranch, aluLatch, regWriteEn, halted, memErr;
    logic [2:0] state;
`ifdef SEQ_RETIRE_CNT_EN
    logic [31:0] retireCount;
`endif
    int pass_cnt = 0;
    int total_cnt = 0;

    kgp_cycle_sequencer dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode),
        .memRead(memRead), .memWrite(memWrite), .regwrite(regwrite),
        .branch(branch), .branchTaken(branchTaken), .memAck(memAck),
        .memReq(memReq), .memWe(memWe), .memIsFetch(memIsFetch),
        .irLoad(irLoad), .pcWrite(pcWrite), .pcSrcBranch(pcSrcBranch),
        .aluLatch(aluLatch), .regWriteEn(regWriteEn), .state(state),
        .halted(halted), .memErr(memErr)
`ifdef SEQ_RETIRE_CNT_EN
        , .retireCount(retireCount)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] in;
        logic [5:0] op;
        logic [2:0] st;
        logic [9:0] out;
    } vec_t;
    vec_t tv[36];

    task automatic chk(input string nm, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    function automatic int outs();
        return int'({memReq, memWe, memIsFetch, irLoad, pcWrite, pcSrcBranch, aluLatch, regWriteEn, halted, memErr});
    endfunction

    task automatic set_in(input logic [7:0] v, input logic [5:0] op);
        {rst_n, run, memRead, memWrite, regwrite, branch, branchTaken, memAck} = v;
        opcode = op;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // in = {rst_n,run,memRead,memWrite,regwrite,branch,branchTaken,memAck}
        // out = {memReq,memWe,memIsFetch,irLoad,pcWrite,pcSrcBranch,aluLatch,regWriteEn,halted,memErr}
        tv[0]  = '{8'b10000000, 6'd0,  3'd0, 10'b0000000000};
        tv[1]  = '{8'b11001000, 6'd0,  3'd0, 10'b0000000000};
        tv[2]  = '{8'b11001001, 6'd0,  3'd1, 10'b1011100000};
        tv[3]  = '{8'b11001000, 6'd0,  3'd2, 10'b0000000000};
        tv[4]  = '{8'b11001000, 6'd0,  3'd3, 10'b0000001000};
        tv[5]  = '{8'b11001000, 6'd0,  3'd5, 10'b0000000100};
        tv[6]  = '{8'b11101000, 6'd0,  3'd1, 10'b1010000000};
        tv[7]  = '{8'b11101000, 6'd0,  3'd1, 10'b1010000000};
        tv[8]  = '{8'b11101000, 6'd0,  3'd1, 10'b1010000000};
        tv[9]  = '{8'b11101001, 6'd0,  3'd1, 10'b1011100000};
        tv[10] = '{8'b11101000, 6'd0,  3'd2, 10'b0000000000};
        tv[11] = '{8'b11101000, 6'd0,  3'd3, 10'b0000001000};
        tv[12] = '{8'b11101001, 6'd0,  3'd4, 10'b1000000000};
        tv[13] = '{8'b11101000, 6'd0,  3'd5, 10'b0000000100};
        tv[14] = '{8'b11010001, 6'd0,  3'd1, 10'b1011100000};
        tv[15] = '{8'b11010000, 6'd0,  3'd2, 10'b0000000000};
        tv[16] = '{8'b11010000, 6'd0,  3'd3, 10'b0000001000};
        tv[17] = '{8'b11010000, 6'd0,  3'd4, 10'b1100000000};
        tv[18] = '{8'b11010001, 6'd0,  3'd4, 10'b1100000000};
        tv[19] = '{8'b11000111, 6'd0,  3'd1, 10'b1011100000};
        tv[20] = '{8'b11000111, 6'd0,  3'd2, 10'b0000000000};
        tv[21] = '{8'b11000111, 6'd0,  3'd3, 10'b0000111000};
        tv[22] = '{8'b11000101, 6'd0,  3'd1, 10'b1011100000};
        tv[23] = '{8'b11000101, 6'd0,  3'd2, 10'b0000000000};
        tv[24] = '{8'b10000100, 6'd0,  3'd3, 10'b0000001000};
        tv[25] = '{8'b10000001, 6'd0,  3'd0, 10'b0000000000};
        tv[26] = '{8'b11000000, 6'd0,  3'd0, 10'b0000000000};
        tv[27] = '{8'b11000001, 6'h3F, 3'd1, 10'b1011100000};
        tv[28] = '{8'b11000000, 6'h3F, 3'd2, 10'b0000000000};
        tv[29] = '{8'b10000001, 6'h3F, 3'd6, 10'b0000000010};
        tv[30] = '{8'b11000000, 6'd0,  3'd6, 10'b0000000010};
        tv[31] = '{8'b01000000, 6'd0,  3'd6, 10'b0000000010};
        tv[32] = '{8'b10000000, 6'd0,  3'd0, 10'b0000000000};
        tv[33] = '{8'b11001000, 6'd0,  3'd0, 10'b0000000000};
        tv[34] = '{8'b01001000, 6'd0,  3'd1, 10'b1010000000};
        tv[35] = '{8'b10001000, 6'd0,  3'd0, 10'b0000000000};

        set_in(8'b00000000, 6'd0);
        cyc();
        for (int i = 0; i < 36; i++) begin
            set_in(tv[i].in, tv[i].op);
            @(negedge clk);
            chk($sformatf("vec%0d_state", i), int'(state), int'(tv[i].st));
            chk($sformatf("vec%0d_outs", i), outs(), int'(tv[i].out));
            cyc();
        end

        // fetch never acknowledged: error after the 16th request cycle
        set_in(8'b00000000, 6'd0);
        cyc();
        set_in(8'b11001000, 6'd0);
        cyc();
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            chk($sformatf("to_wait%0d_state", k), int'(state), 1);
            chk($sformatf("to_wait%0d_err", k), int'(memErr), 0);
            cyc();
        end
        @(negedge clk);
        chk("to_err_state", int'(state), 7);
        chk("to_err_outs", outs(), 10'b0000000001);
        memAck = 1'b1;
        cyc();
        cyc();
        @(negedge clk);
        chk("to_err_sticky_state", int'(state), 7);
        chk("to_err_sticky_outs", outs(), 10'b0000000001);

        // ack in the 16th request cycle wins over the timeout
        set_in(8'b00000000, 6'd0);
        cyc();
        set_in(8'b11001000, 6'd0);
        cyc();
        for (int k = 1; k <= 15; k++) cyc();
        memAck = 1'b1;
        @(negedge clk);
        chk("to_late_ack_state", int'(state), 1);
        chk("to_late_ack_outs", outs(), 10'b1011100000);
        cyc();
        memAck = 1'b0;
        @(negedge clk);
        chk("to_late_ack_decode", int'(state), 2);
        chk("to_late_ack_noerr", int'(memErr), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
